// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage definitions: reset/exception vectors,
// fetch sequencer state encoding and IM address width helper.
package mips_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam int          IM_WORDS_DEF = 1024;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    function automatic int im_aw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/pc_range_check.sv
// Flags an address that is misaligned or outside a word-addressed
// memory window starting at BASE; wraps below BASE count as outside.
module pc_range_check
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] BASE  = RESET_PC_DEF,
    parameter int          WORDS = IM_WORDS_DEF
) (
    input  logic [31:0] addr,
    output logic        misaligned,
    output logic        out_of_range
);

    localparam logic [31:0] LIMIT = 32'(WORDS) << 2;

    assign misaligned   = |addr[1:0];
    assign out_of_range = (addr - BASE) >= LIMIT;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch PC sequencer: owns the PC, applies redirects,
// stalls and exceptions, and qualifies/flushes the IF/ID register.
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       redir_valid,
    input  logic [31:0]                redir_pc,
    input  logic                       exc_req,
    output logic [31:0]                pc,
    output logic [31:0]                pc4,
    output logic [im_aw(IM_WORDS)-1:0] im_addr,
    output logic                       fetch_valid,
    output logic                       flush,
    output logic                       fault
);

    localparam int AW = im_aw(IM_WORDS);

    fetch_state_t state, state_n;
    logic [31:0]  pend, pend_n, pc_n;
    logic         flush_n, chk_en;
    logic         mis, oor, bad;

    assign pc4     = pc + 32'd4;
    assign im_addr = AW'((pc - RESET_PC) >> 2);

    assign fetch_valid = (state == RUN || state == HOLD)
                         && !stall && !fault;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        pend_n  = pend;
        flush_n = 1'b0;
        chk_en  = 1'b0;
        unique case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (exc_req) begin
                    pc_n    = EXC_VEC;
                    flush_n = 1'b1;
                end else if (redir_valid && !stall) begin
                    pc_n    = redir_pc;
                    flush_n = 1'b1;
                    chk_en  = 1'b1;
                end else if (redir_valid) begin
                    pend_n  = redir_pc;
                    state_n = HOLD;
                end else if (!stall) begin
                    pc_n    = pc4;
                    chk_en  = 1'b1;
                end
            end
            HOLD: begin
                if (exc_req) begin
                    pc_n    = EXC_VEC;
                    flush_n = 1'b1;
                    state_n = RUN;
                end else if (stall) begin
                    if (redir_valid) pend_n = redir_pc;
                end else begin
                    // a redirect arriving as the stall lifts is the newer one
                    pc_n    = redir_valid ? redir_pc : pend;
                    flush_n = 1'b1;
                    chk_en  = 1'b1;
                    state_n = RUN;
                end
            end
            FAULT: ;
            default: ;
        endcase
    end

    // exception vector lives outside IM, so it is never range-checked
    pc_range_check #(
        .BASE  (RESET_PC),
        .WORDS (IM_WORDS)
    ) u_chk (
        .addr         (pc_n),
        .misaligned   (mis),
        .out_of_range (oor)
    );

    assign bad = chk_en && (mis || oor);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
            pend  <= '0;
            flush <= 1'b0;
            fault <= 1'b0;
        end else begin
            pc   <= pc_n;
            pend <= pend_n;
            if (bad) begin
                state <= FAULT;
                fault <= 1'b1;
                flush <= 1'b0;
            end else begin
                state <= state_n;
                flush <= flush_n;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch state pushed
// per driven cycle, popped and compared just after the clock edge.
module tb_fetch_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        ft;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        exc_req = 1'b0;
    logic [31:0] pc, pc4;
    logic [9:0]  im_addr;
    logic        fetch_valid, flush, fault;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .exc_req     (exc_req),
        .pc          (pc),
        .pc4         (pc4),
        .im_addr     (im_addr),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .fault       (fault)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input exp_t e);
        logic [31:0] off;
        off = e.pc - 32'h0000_3000;
        chk("pc", pc, e.pc);
        chk("pc4", pc4, e.pc + 32'd4);
        chk("im_addr", {22'b0, im_addr}, {22'b0, off[11:2]});
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.fv});
        chk("flush", {31'b0, flush}, {31'b0, e.fl});
        chk("fault", {31'b0, fault}, {31'b0, e.ft});
    endtask

    task automatic cyc(input logic st, input logic rv,
                       input logic [31:0] rp, input logic ex,
                       input logic [31:0] epc, input logic efv,
                       input logic efl, input logic eft);
        exp_t e;
        stall       = st;
        redir_valid = rv;
        redir_pc    = rp;
        exc_req     = ex;
        e.pc = epc;
        e.fv = efv;
        e.fl = efl;
        e.ft = eft;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk_state(e);
        end
    endtask

    task automatic idle(input logic [31:0] epc, input logic efv,
                        input logic efl, input logic eft);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, epc, efv, efl, eft);
    endtask

    task automatic do_reset();
        exp_t e;
        stall       = 1'b0;
        redir_valid = 1'b0;
        exc_req     = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        e.pc = 32'h0000_3000; e.fv = 1'b0; e.fl = 1'b0; e.ft = 1'b0;
        chk_state(e);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_state(e);
    endtask

    initial begin
        exp_t e;

        // boot then free-run
        do_reset();
        idle(32'h3000, 1, 0, 0);
        idle(32'h3004, 1, 0, 0);
        idle(32'h3008, 1, 0, 0);
        idle(32'h300C, 1, 0, 0);

        // redirect under stall, applied when stall drops
        cyc(1, 1, 32'h3040, 0, 32'h300C, 0, 0, 0);
        cyc(1, 0, 32'h0,    0, 32'h300C, 0, 0, 0);
        cyc(0, 0, 32'h0,    0, 32'h3040, 1, 1, 0);
        idle(32'h3044, 1, 0, 0);

        // exception beats redirect and stall
        cyc(1, 1, 32'h3080, 1, 32'h4180, 0, 1, 0);
        cyc(1, 0, 32'h0,    0, 32'h4180, 0, 0, 0);
        cyc(0, 1, 32'h3100, 0, 32'h3100, 1, 1, 0);
        idle(32'h3104, 1, 0, 0);

        // misaligned redirect faults; everything else ignored
        cyc(0, 1, 32'h3002, 0, 32'h3002, 0, 0, 1);
        cyc(0, 1, 32'h3040, 0, 32'h3002, 0, 0, 1);
        cyc(1, 1, 32'h3080, 1, 32'h3002, 0, 0, 1);
        idle(32'h3002, 0, 0, 1);

        // sequential run off the end of instruction memory
        do_reset();
        idle(32'h3000, 1, 0, 0);
        for (int i = 1; i < 1024; i++)
            idle(32'h3000 + 32'(i) * 4, 1, 0, 0);
        idle(32'h4000, 0, 0, 1);
        idle(32'h4000, 0, 0, 1);
        idle(32'h4000, 0, 0, 1);

        // asynchronous reset in the middle of HOLD
        do_reset();
        idle(32'h3000, 1, 0, 0);
        idle(32'h3004, 1, 0, 0);
        cyc(1, 1, 32'h3200, 0, 32'h3004, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        stall       = 1'b0;
        redir_valid = 1'b0;
        e.pc = 32'h3000; e.fv = 1'b0; e.fl = 1'b0; e.ft = 1'b0;
        chk_state(e);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_state(e);
        idle(32'h3000, 1, 0, 0);
        idle(32'h3004, 1, 0, 0);
        idle(32'h3008, 1, 0, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
